// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers
module axi_lite_slave_regs #(
  parameter int          NUM_REGS = 4,
  parameter logic [31:0] RST_VAL0 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] S_AWADDR,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  input  logic [31:0] S_ARADDR,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  output logic [31:0] reg0_out
);

  localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

  logic [31:0]      r_regs [NUM_REGS];
  logic             r_aw_full;
  logic             r_aw_ok;
  logic [IDX_W-1:0] r_aw_idx;
  logic             r_w_full;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_arready;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic             w_aw_full_nxt;
  logic             w_w_full_nxt;
  logic             w_bvalid_nxt;
  logic             w_rvalid_nxt;
  logic [IDX_W-1:0] w_ar_idx;

  assign w_aw_hs  = S_AWVALID & r_awready;
  assign w_w_hs   = S_WVALID & r_wready;
  assign w_ar_hs  = S_ARVALID & r_arready;
  assign w_commit = r_aw_full & r_w_full;
  assign w_ar_idx = S_ARADDR[IDX_W+1:2];

  // Buffers cannot refill while a response is pending, so commit and handshake never collide.
  assign w_aw_full_nxt = w_commit ? 1'b0 : (r_aw_full | w_aw_hs);
  assign w_w_full_nxt  = w_commit ? 1'b0 : (r_w_full | w_w_hs);
  assign w_bvalid_nxt  = w_commit | (r_bvalid & ~S_BREADY);
  assign w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~S_RREADY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == 0) ? RST_VAL0 : 32'h0;
      r_aw_full <= 1'b0;
      r_aw_ok   <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= 32'h0;
      r_w_strb  <= 4'h0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= 2'b00;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_awready <= ~w_aw_full_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_full_nxt & ~w_bvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_aw_hs) begin
        r_aw_idx <= S_AWADDR[IDX_W+1:2];
        r_aw_ok  <= (S_AWADDR < ADDR_LIMIT);
      end
      if (w_w_hs) begin
        r_w_data <= S_WDATA;
        r_w_strb <= S_WSTRB;
      end
      if (w_commit) begin
        r_bresp <= r_aw_ok ? 2'b00 : 2'b10;
        if (r_aw_ok) begin
          for (int b = 0; b < 4; b++) begin
            if (r_w_strb[b]) r_regs[r_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
          end
        end
      end
      // Read samples the pre-edge register value, so a same-edge commit returns old data.
      if (w_ar_hs) begin
        if (S_ARADDR < ADDR_LIMIT) begin
          r_rdata <= r_regs[w_ar_idx];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= 32'h0;
          r_rresp <= 2'b10;
        end
      end
    end
  end

  assign S_AWREADY = r_awready;
  assign S_WREADY  = r_wready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = r_arready;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;
  assign reg0_out  = r_regs[0];

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - directed and randomized bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;

  localparam int          NREGS = 4;
  localparam logic [31:0] RST0  = 32'hAABB_CCDD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;
  logic [31:0] reg0_out;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model [NREGS];

  axi_lite_slave_regs #(.NUM_REGS(NREGS), .RST_VAL0(RST0)) dut (
    .clk(clk), .reset_n(reset_n),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .reg0_out(reg0_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = (i == 0) ? RST0 : 32'h0;
  endtask

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a < NREGS * 4) return model[a / 4];
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a < NREGS * 4) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < NREGS * 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    S_BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 30) begin
      if (!aw_done && n >= aw_dly) begin S_AWVALID = 1'b1; S_AWADDR = a; end
      if (!w_done && n >= w_dly) begin S_WVALID = 1'b1; S_WDATA = d; S_WSTRB = s; end
      aw_fire = S_AWVALID && S_AWREADY;
      w_fire  = S_WVALID && S_WREADY;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1; S_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  S_WVALID = 1'b0;  end
      n++;
    end
    check("wr_handshakes_done", 32'(aw_done && w_done), 32'd1);
    check("wr_bvalid_before_commit", 32'(S_BVALID), 32'd0);
    @(posedge clk); #1;
    check("wr_bvalid", 32'(S_BVALID), 32'd1);
    check("wr_bresp", 32'(S_BRESP), 32'(exp_resp(a)));
    model_write(a, d, s);
    @(posedge clk); #1;
    check("wr_bvalid_cleared", 32'(S_BVALID), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int rr_dly);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    n = 0;
    S_RREADY = 1'b0;
    S_ARVALID = 1'b1;
    S_ARADDR = a;
    while (!S_ARREADY && n < 20) begin @(posedge clk); #1; n++; end
    check("rd_arready_seen", 32'(S_ARREADY), 32'd1);
    ed = exp_rdata(a);
    er = exp_resp(a);
    @(posedge clk); #1;
    S_ARVALID = 1'b0;
    check("rd_rvalid", 32'(S_RVALID), 32'd1);
    check("rd_rdata", S_RDATA, ed);
    check("rd_rresp", 32'(S_RRESP), 32'(er));
    for (int i = 0; i < rr_dly; i++) begin
      @(posedge clk); #1;
      check("rd_rdata_hold", S_RDATA, ed);
      check("rd_arready_low", 32'(S_ARREADY), 32'd0);
    end
    S_RREADY = 1'b1;
    @(posedge clk); #1;
    S_RREADY = 1'b0;
    check("rd_rvalid_cleared", 32'(S_RVALID), 32'd0);
    check("rd_arready_back", 32'(S_ARREADY), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
    S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(S_AWREADY), 32'd0);
    check("rst_wready", 32'(S_WREADY), 32'd0);
    check("rst_arready", 32'(S_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_RVALID), 32'd0);
    check("rst_rdata", S_RDATA, 32'h0);
    check("rst_reg0_out", reg0_out, RST0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awready", 32'(S_AWREADY), 32'd1);
    check("post_rst_wready", 32'(S_WREADY), 32'd1);
    check("post_rst_arready", 32'(S_ARREADY), 32'd1);

    // Basic write then read of register 1
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(32'h4, 0);

    // Byte-lane write to register 0
    do_write(32'h0, 32'h1122_3344, 4'b0101, 0, 0);
    check("strb_reg0_out", reg0_out, 32'hAA22_CC44);

    // W leads AW by three cycles, response back-pressured
    S_BREADY = 1'b0;
    S_WVALID = 1'b1; S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF;
    @(posedge clk); #1;
    S_WVALID = 1'b0;
    check("wfirst_wready_low", 32'(S_WREADY), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("wfirst_wready_still_low", 32'(S_WREADY), 32'd0);
      check("wfirst_no_bvalid", 32'(S_BVALID), 32'd0);
    end
    S_AWVALID = 1'b1; S_AWADDR = 32'h8;
    @(posedge clk); #1;
    S_AWVALID = 1'b0;
    check("wfirst_bvalid_not_yet", 32'(S_BVALID), 32'd0);
    @(posedge clk); #1;
    check("wfirst_bvalid", 32'(S_BVALID), 32'd1);
    model_write(32'h8, 32'h1234_5678, 4'hF);
    repeat (5) begin
      @(posedge clk); #1;
      check("bstall_bvalid", 32'(S_BVALID), 32'd1);
      check("bstall_bresp", 32'(S_BRESP), 32'd0);
      check("bstall_awready", 32'(S_AWREADY), 32'd0);
      check("bstall_wready", 32'(S_WREADY), 32'd0);
    end
    S_BREADY = 1'b1;
    @(posedge clk); #1;
    check("bstall_release_bvalid", 32'(S_BVALID), 32'd0);
    check("bstall_release_awready", 32'(S_AWREADY), 32'd1);
    do_read(32'h8, 1);

    // Out-of-range write and read
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 1, 0);
    for (int i = 0; i < NREGS; i++) do_read(32'(i * 4), 0);
    do_read(32'h10, 1);

    // Empty strobe changes nothing
    do_write(32'hC, 32'hCAFE_F00D, 4'h0, 0, 2);
    do_read(32'hC, 0);

    // Read racing a write commit to the same register
    do_write(32'h4, 32'h3, 4'hF, 0, 0);
    S_BREADY = 1'b1; S_RREADY = 1'b0;
    S_AWVALID = 1'b1; S_AWADDR = 32'h4; S_WVALID = 1'b1; S_WDATA = 32'h5; S_WSTRB = 4'hF;
    @(posedge clk); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    S_ARVALID = 1'b1; S_ARADDR = 32'h4;
    check("race_arready", 32'(S_ARREADY), 32'd1);
    @(posedge clk); #1;
    S_ARVALID = 1'b0;
    check("race_bvalid", 32'(S_BVALID), 32'd1);
    check("race_rvalid", 32'(S_RVALID), 32'd1);
    check("race_old_data", S_RDATA, 32'h3);
    model_write(32'h4, 32'h5, 4'hF);
    repeat (4) begin
      @(posedge clk); #1;
      check("race_arready_low", 32'(S_ARREADY), 32'd0);
      check("race_rdata_hold", S_RDATA, 32'h3);
    end
    S_RREADY = 1'b1;
    @(posedge clk); #1;
    S_RREADY = 1'b0;
    check("race_rvalid_cleared", 32'(S_RVALID), 32'd0);
    do_read(32'h4, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 2)));
    end
    check("rand_reg0_out", reg0_out, model[0]);

    // Reset with only the address beat buffered
    S_AWVALID = 1'b1; S_AWADDR = 32'h4;
    @(posedge clk); #1;
    S_AWVALID = 1'b0;
    check("midrst_awready_low", 32'(S_AWREADY), 32'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_wready_in_reset", 32'(S_WREADY), 32'd0);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("midrst_awready", 32'(S_AWREADY), 32'd1);
    check("midrst_wready", 32'(S_WREADY), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_bvalid", 32'(S_BVALID), 32'd0);
    end
    check("midrst_reg0_out", reg0_out, RST0);
    for (int i = 0; i < NREGS; i++) do_read(32'(i * 4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
